muldiv_sequencer: RTL and testbench

- Multi-cycle execution unit for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, alongside the single-cycle ALU in the EX stage.
- Accepts an M-type op from EX and holds the pipeline through the stall output until the result is ready.
- Multiply uses a fixed-latency registered product. Divide uses a 32-iteration restoring algorithm, with a 1-cycle fast path for divide-by-zero and signed overflow.
- Flush from the hazard unit aborts an in-flight op.

---
 rtl/muldiv_sequencer.sv | 113 +++++++++++
 tb/tb_muldiv_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit that stalls EX until its result is ready.
module muldiv_sequencer #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
    state_t state, next;
    logic [4:0] cnt;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] quo, rem, dvs;
    logic mul_hi, rem_op, neg_q, neg_r;
    logic is_signed, neg_a, neg_b, sa, sb, fast;
    logic [2*XLEN-1:0] a64, b64;
    logic [XLEN:0] rem_sh;
    logic ge;
    logic [XLEN-1:0] rem_n, quo_n;
    assign sa        = funct3[0] ^ funct3[1];
    assign sb        = funct3[1:0] == 2'b01;
    assign a64       = {{XLEN{sa & src_a[XLEN-1]}}, src_a};
    assign b64       = {{XLEN{sb & src_b[XLEN-1]}}, src_b};
    assign is_signed = ~funct3[0];
    assign neg_a     = is_signed & src_a[XLEN-1];
    assign neg_b     = is_signed & src_b[XLEN-1];
    // Divide-by-zero and signed overflow resolve without iterating.
    assign fast      = (src_b == '0) | (is_signed & (src_a == MIN_INT) & (src_b == '1));
    assign rem_sh    = {rem, quo[XLEN-1]};
    assign ge        = rem_sh >= {1'b0, dvs};
    assign rem_n     = ge ? rem_sh[XLEN-1:0] - dvs : rem_sh[XLEN-1:0];
    assign quo_n     = {quo[XLEN-2:0], ge};
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= next;
    end
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = start ? (!funct3[2] ? MUL : (fast ? DONE : DIV)) : IDLE;
            MUL:     next = (cnt == 5'd0) ? DONE : MUL;
            DIV:     next = (cnt == 5'd0) ? DONE : DIV;
            default: next = IDLE;
        endcase
        if (flush) next = IDLE;
    end
    always_comb begin
        stall = start & (state != DONE) & ~flush & reset;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            result <= '0;
            done   <= 1'b0;
            busy   <= 1'b0;
            prod   <= '0;
            quo    <= '0;
            rem    <= '0;
            dvs    <= '0;
            mul_hi <= 1'b0;
            rem_op <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            busy <= next != IDLE;
            if (!flush) begin
                case (state)
                    IDLE: if (start) begin
                        mul_hi <= funct3[1:0] != 2'b00;
                        rem_op <= funct3[1];
                        neg_q  <= neg_a ^ neg_b;
                        neg_r  <= neg_a;
                        prod   <= a64 * b64;
                        quo    <= neg_a ? -src_a : src_a;
                        dvs    <= neg_b ? -src_b : src_b;
                        rem    <= '0;
                        cnt    <= funct3[2] ? 5'd31 : 5'(MUL_STAGES - 1);
                        if (funct3[2] && fast) begin
                            result <= (src_b == '0) ? (funct3[1] ? src_a : '1) : (funct3[1] ? '0 : MIN_INT);
                            done   <= 1'b1;
                        end
                    end
                    MUL: begin
                        if (cnt == 5'd0) begin
                            result <= mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                            done   <= 1'b1;
                        end else cnt <= cnt - 5'd1;
                    end
                    DIV: begin
                        rem <= rem_n;
                        quo <= quo_n;
                        if (cnt == 5'd0) begin
                            result <= rem_op ? (neg_r ? -rem_n : rem_n) : (neg_q ? -quo_n : quo_n);
                            done   <= 1'b1;
                        end else cnt <= cnt - 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and random RV32M ops checked against an arithmetic reference model.
module tb_muldiv_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic flush = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] src_a = '0, src_b = '0;
    logic stall, busy, done;
    logic [31:0] result;
    int vectors = 0;
    int miscompares = 0;
    logic [2:0] rf;
    logic [31:0] ra, rb, held;

    muldiv_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .funct3(funct3),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        logic ovf;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = int'(a);
        ib = int'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (!f[2]) return 3;
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after the result's following IDLE begins.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int lat;
        logic got;
        start = 1'b1; funct3 = f; src_a = a; src_b = b;
        #1 chk("stall_at_accept", stall, 1'b1);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1 lat++;
            if (done) got = 1'b1;
            else if (!stall) chk("stall_held", stall, 1'b1);
        end
        chk("done_seen", got, 1'b1);
        chk($sformatf("latency f=%0d", f), lat, latency(f, a, b));
        chk($sformatf("result f=%0d a=%h b=%h", f, a, b), result, model(f, a, b));
        chk("stall_in_done", stall, 1'b0);
        start = 1'b0;
        @(posedge clk);
        #1 chk("done_pulse", done, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_stall", stall, 1'b0);
        start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_op(3'd4, 32'd100, 32'd7);
        run_op(3'd6, 32'd100, 32'd7);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd0, 32'd3, 32'hFFFF_FFFC);

        held = result;
        start = 1'b1; funct3 = 3'd4; src_a = 32'd1000; src_b = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1 chk("flush_no_early_done", done, 1'b0);
        end
        @(negedge clk);
        flush = 1'b1;
        #1 chk("flush_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("flush_busy", busy, 1'b0);
        chk("flush_done", done, 1'b0);
        chk("flush_result_kept", result, held);
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        run_op(3'd0, 32'd6, 32'd7);

        start = 1'b1; funct3 = 3'd5; src_a = 32'hDEAD_BEEF; src_b = 32'd9;
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_mid_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_done", done, 1'b0);
        chk("rst_mid_result", result, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        funct3 = 3'd0; src_a = 32'd11; src_b = 32'd13;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1 chk($sformatf("b2b_done c=%0d", c), done, (c == 3 || c == 7));
            if (c == 3 || c == 7) chk("b2b_result", result, 32'd143);
        end
        start = 1'b0;
        @(negedge clk);
        repeat (2) @(negedge clk);

        for (int i = 0; i < 40; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            run_op(rf, ra, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
